// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback,
// drives datapath enables and mux selects, resolves branches, waits on the memory
// handshake (with optional timeout), traps illegal encodings and counts retirements.
//
// Handshake: mem_req is held high for the whole access; the access completes in the
// cycle where mem_req and mem_ready are both high, and only then do the access
// enables (IRWrite/PCWrite in FETCH, MemWrite in MEMWRITE) fire. mem_ready is
// ignored outside mem_req states.
module multicycle_control #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 0,
  parameter bit TRAP_HALT   = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             zero,
  input  logic             lt,
  input  logic             ltu,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             AdrSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       ResultSrc,
  output logic [2:0]       ImmSrc,
  output logic [2:0]       Load,
  output logic [1:0]       Store,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state_dbg
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEMADR    = 4'd2;
  localparam logic [3:0] S_MEMREAD   = 4'd3;
  localparam logic [3:0] S_MEMWB     = 4'd4;
  localparam logic [3:0] S_MEMWRITE  = 4'd5;
  localparam logic [3:0] S_EXEC_R    = 4'd6;
  localparam logic [3:0] S_EXEC_I    = 4'd7;
  localparam logic [3:0] S_ALUWB     = 4'd8;
  localparam logic [3:0] S_BRANCH    = 4'd9;
  localparam logic [3:0] S_JAL       = 4'd10;
  localparam logic [3:0] S_JALR      = 4'd11;
  localparam logic [3:0] S_JALR_LINK = 4'd12;
  localparam logic [3:0] S_UPPER     = 4'd13;
  localparam logic [3:0] S_TRAP      = 4'd14;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  // Wait counter only needs to reach MEM_TIMEOUT-1; the timeout fires on that cycle.
  localparam int           TW        = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam bit           TO_EN     = (MEM_TIMEOUT > 0);
  localparam logic [TW-1:0] WAIT_LAST = TW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  logic [3:0]    state, state_next;
  logic [TW-1:0] wait_cnt;
  logic          trap_ill, trap_bus;
  logic          is_mem, timeout, taken;

  // Timeout detection and branch resolution
  always_comb begin
    is_mem  = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
    timeout = TO_EN && is_mem && !mem_ready && (wait_cnt == WAIT_LAST);
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = lt;
      3'b101:  taken = !lt;
      3'b110:  taken = ltu;
      3'b111:  taken = !ltu;
      default: taken = 1'b0;
    endcase
  end

  // Next-state logic, including decode-time legality checks
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:     if (timeout) state_next = S_TRAP;
                   else if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD:  state_next = (funct3 == 3'b011 || funct3[2:1] == 2'b11) ? S_TRAP : S_MEMADR;
          OP_STORE: state_next = (funct3 >= 3'b011) ? S_TRAP : S_MEMADR;
          OP_R:     state_next = S_EXEC_R;
          OP_I:     state_next = S_EXEC_I;
          OP_BR:    state_next = (funct3[2:1] == 2'b01) ? S_TRAP : S_BRANCH;
          OP_JAL:   state_next = S_JAL;
          OP_JALR:  state_next = S_JALR;
          OP_LUI,
          OP_AUIPC: state_next = S_UPPER;
          default:  state_next = S_TRAP;
        endcase
      end
      S_MEMADR:    state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:   if (timeout) state_next = S_TRAP;
                   else if (mem_ready) state_next = S_MEMWB;
      S_MEMWB:     state_next = S_FETCH;
      S_MEMWRITE:  if (timeout) state_next = S_TRAP;
                   else if (mem_ready) state_next = S_FETCH;
      S_EXEC_R,
      S_EXEC_I:    state_next = S_ALUWB;
      S_ALUWB:     state_next = S_FETCH;
      S_BRANCH:    state_next = S_FETCH;
      S_JAL:       state_next = S_ALUWB;
      S_JALR:      state_next = S_JALR_LINK;
      S_JALR_LINK: state_next = S_ALUWB;
      S_UPPER:     state_next = S_ALUWB;
      S_TRAP:      state_next = TRAP_HALT ? S_TRAP : S_FETCH;
      default:     state_next = S_FETCH;
    endcase
  end

  // State, wait counter, trap cause and retirement registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      trap_ill <= 1'b0;
      trap_bus <= 1'b0;
      retired  <= '0;
    end else begin
      state <= state_next;
      if (TO_EN && is_mem && !mem_ready && !timeout) wait_cnt <= wait_cnt + TW'(1);
      else wait_cnt <= '0;
      if (state == S_DECODE && state_next == S_TRAP) trap_ill <= 1'b1;
      else if (timeout) trap_bus <= 1'b1;
      else if (state == S_TRAP && state_next == S_FETCH) begin
        trap_ill <= 1'b0;
        trap_bus <= 1'b0;
      end
      if (state_next == S_FETCH && state != S_FETCH && state != S_TRAP)
        retired <= retired + CNT_W'(1);
    end
  end

  // Per-state datapath controls; everything held low while reset is asserted
  always_comb begin
    mem_req = 1'b0; IRWrite = 1'b0; PCWrite = 1'b0; RegWrite = 1'b0; MemWrite = 1'b0;
    AdrSrc = 1'b0; ALUSrcA = 2'b00; ALUSrcB = 2'b00; ALUOp = 2'b00; ResultSrc = 2'b00;
    if (reset) begin
      case (state)
        S_FETCH: begin
          mem_req = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
          IRWrite = mem_ready; PCWrite = mem_ready;
        end
        S_DECODE:    begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; end
        S_MEMADR:    begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
        S_MEMREAD:   begin mem_req = 1'b1; AdrSrc = 1'b1; end
        S_MEMWB:     begin ResultSrc = 2'b01; RegWrite = 1'b1; end
        S_MEMWRITE:  begin mem_req = 1'b1; AdrSrc = 1'b1; MemWrite = mem_ready; end
        S_EXEC_R:    begin ALUSrcA = 2'b10; ALUOp = 2'b10; end
        S_EXEC_I:    begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; ALUOp = 2'b10; end
        S_ALUWB:     RegWrite = 1'b1;
        S_BRANCH:    begin ALUSrcA = 2'b10; ALUOp = 2'b01; PCWrite = taken; end
        S_JAL:       begin PCWrite = 1'b1; ALUSrcA = 2'b01; ALUSrcB = 2'b10; end
        S_JALR: begin
          ALUSrcA = 2'b10; ALUSrcB = 2'b01; ResultSrc = 2'b10; PCWrite = 1'b1;
        end
        S_JALR_LINK: begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; end
        S_UPPER: begin
          ALUSrcA = (op == OP_LUI) ? 2'b11 : 2'b01; ALUSrcB = 2'b01;
        end
        default: ;
      endcase
    end
  end

  // Immediate format and load/store size, decoded from the instruction in every state
  always_comb begin
    case (op)
      OP_STORE:         ImmSrc = 3'b001;
      OP_BR:            ImmSrc = 3'b010;
      OP_JAL:           ImmSrc = 3'b011;
      OP_LUI, OP_AUIPC: ImmSrc = 3'b100;
      default:          ImmSrc = 3'b000;
    endcase
    case (funct3)
      3'b001:  Load = 3'b001;
      3'b010:  Load = 3'b010;
      3'b100:  Load = 3'b011;
      3'b101:  Load = 3'b100;
      default: Load = 3'b000;
    endcase
    case (funct3)
      3'b001:  Store = 2'b01;
      3'b010:  Store = 2'b10;
      default: Store = 2'b00;
    endcase
  end

  assign illegal   = (state == S_TRAP) && trap_ill;
  assign bus_err   = (state == S_TRAP) && trap_bus;
  assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: a default instance (wait forever, halt on trap,
// 32-bit counter) and a second instance (timeout 4, resume after trap, 4-bit counter)
// share all inputs. Per-cycle control words are queued per instruction and compared.
module tb_multicycle_control;

  localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_JAL = 5,
                 K_JALR = 6, K_LUI = 7, K_AUIPC = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic zero = 1'b0, lt = 1'b0, ltu = 1'b0, mem_ready = 1'b0;

  logic mem_req, IRWrite, PCWrite, RegWrite, MemWrite, AdrSrc, illegal, bus_err;
  logic [1:0] ALUSrcA, ALUSrcB, ALUOp, ResultSrc, Store;
  logic [2:0] ImmSrc, Load;
  logic [31:0] retired;
  logic [3:0] state_dbg;

  logic mem_req_b, IRWrite_b, PCWrite_b, RegWrite_b, MemWrite_b, AdrSrc_b, illegal_b, bus_err_b;
  logic [1:0] ALUSrcA_b, ALUSrcB_b, ALUOp_b, ResultSrc_b, Store_b;
  logic [2:0] ImmSrc_b, Load_b;
  logic [3:0] retired_b;
  logic [3:0] state_dbg_b;

  multicycle_control dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .zero(zero), .lt(lt), .ltu(ltu),
    .mem_ready(mem_ready), .mem_req(mem_req), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .Load(Load),
    .Store(Store), .illegal(illegal), .bus_err(bus_err), .retired(retired),
    .state_dbg(state_dbg)
  );

  multicycle_control #(.CNT_W(4), .MEM_TIMEOUT(4), .TRAP_HALT(1'b0)) dut_b (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .zero(zero), .lt(lt), .ltu(ltu),
    .mem_ready(mem_ready), .mem_req(mem_req_b), .IRWrite(IRWrite_b), .PCWrite(PCWrite_b),
    .RegWrite(RegWrite_b), .MemWrite(MemWrite_b), .AdrSrc(AdrSrc_b), .ALUSrcA(ALUSrcA_b),
    .ALUSrcB(ALUSrcB_b), .ALUOp(ALUOp_b), .ResultSrc(ResultSrc_b), .ImmSrc(ImmSrc_b),
    .Load(Load_b), .Store(Store_b), .illegal(illegal_b), .bus_err(bus_err_b),
    .retired(retired_b), .state_dbg(state_dbg_b)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [13:0] act, act_b;
  assign act   = {mem_req, IRWrite, PCWrite, RegWrite, MemWrite, AdrSrc,
                  ALUSrcA, ALUSrcB, ALUOp, ResultSrc};
  assign act_b = {mem_req_b, IRWrite_b, PCWrite_b, RegWrite_b, MemWrite_b, AdrSrc_b,
                  ALUSrcA_b, ALUSrcB_b, ALUOp_b, ResultSrc_b};

  int checks = 0;
  int errors = 0;
  logic [13:0] exp_q[$];
  logic        rdy_q[$];
  logic [31:0] exp_ret;
  logic [3:0]  exp_ret_b;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       z, l, lu;
    int         kind;
    int         taken;
    logic [2:0] imm;
    logic [2:0] ld;
    logic [1:0] st;
  } vec_t;
  vec_t vecs[17];

  typedef struct { logic [6:0] op; logic [2:0] f3; } bad_t;
  bad_t bads[5];

  // Control word: mem_req, IRWrite, PCWrite, RegWrite, MemWrite, AdrSrc, A, B, ALUOp, ResultSrc
  function automatic logic [13:0] cw(input int mr, ir, pc, rw, mw, adr, a, b, alu, rs);
    return {1'(mr), 1'(ir), 1'(pc), 1'(rw), 1'(mw), 1'(adr), 2'(a), 2'(b), 2'(alu), 2'(rs)};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic push_w(input logic [13:0] w, input logic rdy);
    exp_q.push_back(w);
    rdy_q.push_back(rdy);
  endtask

  // Non-memory states: mem_ready is driven randomly since it must be ignored there
  task automatic push_any(input logic [13:0] w);
    push_w(w, 1'($urandom_range(0, 1)));
  endtask

  // Expected control sequence for one instruction; waits = mem_ready-low cycles in the data access
  task automatic push_instr(input int kind, input int taken, input int waits);
    logic [13:0] aluwb;
    aluwb = cw(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    push_w(cw(1, 1, 1, 0, 0, 0, 0, 2, 0, 2), 1'b1);
    push_any(cw(0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    case (kind)
      K_R:  begin push_any(cw(0, 0, 0, 0, 0, 0, 2, 0, 2, 0)); push_any(aluwb); end
      K_I:  begin push_any(cw(0, 0, 0, 0, 0, 0, 2, 1, 2, 0)); push_any(aluwb); end
      K_LD: begin
        push_any(cw(0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
        for (int i = 0; i < waits; i++) push_w(cw(1, 0, 0, 0, 0, 1, 0, 0, 0, 0), 1'b0);
        push_w(cw(1, 0, 0, 0, 0, 1, 0, 0, 0, 0), 1'b1);
        push_any(cw(0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
      end
      K_ST: begin
        push_any(cw(0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
        for (int i = 0; i < waits; i++) push_w(cw(1, 0, 0, 0, 0, 1, 0, 0, 0, 0), 1'b0);
        push_w(cw(1, 0, 0, 0, 1, 1, 0, 0, 0, 0), 1'b1);
      end
      K_BR:  push_any(cw(0, 0, taken, 0, 0, 0, 2, 0, 1, 0));
      K_JAL: begin push_any(cw(0, 0, 1, 0, 0, 0, 1, 2, 0, 0)); push_any(aluwb); end
      K_JALR: begin
        push_any(cw(0, 0, 1, 0, 0, 0, 2, 1, 0, 2));
        push_any(cw(0, 0, 0, 0, 0, 0, 1, 2, 0, 0));
        push_any(aluwb);
      end
      K_LUI:   begin push_any(cw(0, 0, 0, 0, 0, 0, 3, 1, 0, 0)); push_any(aluwb); end
      default: begin push_any(cw(0, 0, 0, 0, 0, 0, 1, 1, 0, 0)); push_any(aluwb); end
    endcase
  endtask

  // Apply n queued cycles: drive mem_ready after a rising edge, compare on the falling edge
  task automatic run_n(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      if (exp_q.size() == 0) break;
      mem_ready = rdy_q.pop_front();
      @(negedge clk);
      check(name, 32'(act), 32'(exp_q.pop_front()));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic retire_check(input string name);
    exp_ret   = exp_ret + 32'd1;
    exp_ret_b = exp_ret_b + 4'd1;
    check({name, "_retired"}, retired, exp_ret);
    check({name, "_retired_b"}, 32'(retired_b), 32'(exp_ret_b));
  endtask

  task automatic run_instr(input string name, input int kind, input int taken, input int waits);
    push_instr(kind, taken, waits);
    run_n(name, exp_q.size());
    retire_check(name);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    check("reset_ctl", 32'(act), 32'd0);
    check("reset_ctl_b", 32'(act_b), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_ret = 32'd0;
    exp_ret_b = 4'd0;
    exp_q.delete();
    rdy_q.delete();
  endtask

  initial begin
    vecs[0]  = '{7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, K_R,     0, 3'b000, 3'b000, 2'b00};
    vecs[1]  = '{7'b0010011, 3'b000, 1'b0, 1'b0, 1'b0, K_I,     0, 3'b000, 3'b000, 2'b00};
    vecs[2]  = '{7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, K_LD,    0, 3'b000, 3'b010, 2'b00};
    vecs[3]  = '{7'b0000011, 3'b100, 1'b0, 1'b0, 1'b0, K_LD,    0, 3'b000, 3'b011, 2'b00};
    vecs[4]  = '{7'b0000011, 3'b101, 1'b0, 1'b0, 1'b0, K_LD,    0, 3'b000, 3'b100, 2'b00};
    vecs[5]  = '{7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, K_ST,    0, 3'b001, 3'b000, 2'b10};
    vecs[6]  = '{7'b0100011, 3'b000, 1'b0, 1'b0, 1'b0, K_ST,    0, 3'b001, 3'b000, 2'b00};
    vecs[7]  = '{7'b0100011, 3'b001, 1'b0, 1'b0, 1'b0, K_ST,    0, 3'b001, 3'b000, 2'b01};
    vecs[8]  = '{7'b1100011, 3'b000, 1'b1, 1'b0, 1'b0, K_BR,    1, 3'b010, 3'b000, 2'b00};
    vecs[9]  = '{7'b1100011, 3'b100, 1'b0, 1'b0, 1'b1, K_BR,    0, 3'b010, 3'b000, 2'b00};
    vecs[10] = '{7'b1100011, 3'b101, 1'b0, 1'b1, 1'b0, K_BR,    0, 3'b010, 3'b000, 2'b00};
    vecs[11] = '{7'b1100011, 3'b110, 1'b0, 1'b0, 1'b1, K_BR,    1, 3'b010, 3'b000, 2'b00};
    vecs[12] = '{7'b1100011, 3'b111, 1'b1, 1'b1, 1'b0, K_BR,    1, 3'b010, 3'b000, 2'b00};
    vecs[13] = '{7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0, K_JAL,   0, 3'b011, 3'b000, 2'b00};
    vecs[14] = '{7'b1100111, 3'b000, 1'b0, 1'b0, 1'b0, K_JALR,  0, 3'b000, 3'b000, 2'b00};
    vecs[15] = '{7'b0110111, 3'b000, 1'b0, 1'b0, 1'b0, K_LUI,   0, 3'b100, 3'b000, 2'b00};
    vecs[16] = '{7'b0010111, 3'b000, 1'b0, 1'b0, 1'b0, K_AUIPC, 0, 3'b100, 3'b000, 2'b00};
    bads[0] = '{7'b0000011, 3'b011};
    bads[1] = '{7'b0000011, 3'b110};
    bads[2] = '{7'b0100011, 3'b011};
    bads[3] = '{7'b1100011, 3'b010};
    bads[4] = '{7'b1100011, 3'b011};
    exp_ret = 32'd0;
    exp_ret_b = 4'd0;

    // Reset state
    @(negedge clk);
    check("rst_ctl", 32'(act), 32'd0);
    check("rst_flags", {30'd0, illegal, bus_err}, 32'd0);
    check("rst_retired", retired, 32'd0);
    check("rst_retired_b", 32'(retired_b), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Table-driven instruction classes with zero-wait memory
    for (int v = 0; v < 17; v++) begin
      op = vecs[v].op; funct3 = vecs[v].f3;
      zero = vecs[v].z; lt = vecs[v].l; ltu = vecs[v].lu;
      #1;
      check("immsrc", 32'(ImmSrc), 32'(vecs[v].imm));
      if (vecs[v].kind == K_LD) check("load_sz", 32'(Load), 32'(vecs[v].ld));
      if (vecs[v].kind == K_ST) check("store_sz", 32'(Store), 32'(vecs[v].st));
      run_instr("vec", vecs[v].kind, vecs[v].taken, 0);
    end

    // lw with three wait cycles in MEMREAD, sw with two in MEMWRITE
    op = 7'b0000011; funct3 = 3'b010;
    run_instr("lw_wait", K_LD, 0, 3);
    op = 7'b0100011; funct3 = 3'b010;
    run_instr("sw_wait", K_ST, 0, 2);

    // bne not-equal then equal
    op = 7'b1100011; funct3 = 3'b001; zero = 1'b0;
    run_instr("bne_taken", K_BR, 1, 0);
    zero = 1'b1;
    run_instr("bne_not", K_BR, 0, 0);

    // add x3,x1,x2 from reset: retired 0 -> 1
    do_reset();
    op = 7'b0110011; funct3 = 3'b000;
    run_instr("add", K_R, 0, 0);

    // Illegal opcode parks in TRAP with TRAP_HALT=1
    op = 7'b0000000;
    push_w(cw(1, 1, 1, 0, 0, 0, 0, 2, 0, 2), 1'b1);
    push_any(cw(0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    run_n("ill_seq", 2);
    mem_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("ill_flag", 32'(illegal), 32'd1);
      check("ill_ctl", 32'(act), 32'd0);
      @(posedge clk);
      #1;
    end
    check("ill_retired", retired, exp_ret);
    reset = 1'b0;
    #2;
    check("ill_rst_ctl", 32'(act), 32'd0);
    check("ill_rst_flag", 32'(illegal), 32'd0);
    check("ill_rst_retired", retired, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_ret = 32'd0;
    exp_ret_b = 4'd0;
    @(negedge clk);
    check("release_fetch", 32'(mem_req), 32'd1);
    @(posedge clk);
    #1;

    // Illegal funct3 for load/store/branch
    for (int i = 0; i < 5; i++) begin
      do_reset();
      op = bads[i].op; funct3 = bads[i].f3;
      push_w(cw(1, 1, 1, 0, 0, 0, 0, 2, 0, 2), 1'b1);
      push_any(cw(0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
      run_n("bad_f3_seq", 2);
      @(negedge clk);
      check("bad_f3_illegal", 32'(illegal), 32'd1);
      check("bad_f3_ctl", 32'(act), 32'd0);
    end

    // Reset in MEMWRITE with mem_ready high: no store may fire
    do_reset();
    op = 7'b0100011; funct3 = 3'b010;
    push_instr(K_ST, 0, 0);
    run_n("mid_seq", 3);
    mem_ready = 1'b1;
    reset = 1'b0;
    #2;
    check("mid_rst_ctl", 32'(act), 32'd0);
    check("mid_rst_retired", retired, 32'd0);
    exp_q.delete();
    rdy_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_ret = 32'd0;
    exp_ret_b = 4'd0;

    // Memory timeout in FETCH on the second instance
    do_reset();
    mem_ready = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 5) begin
        check("to_bus_err", 32'(bus_err_b), 32'd1);
        check("to_ctl", 32'(act_b), 32'd0);
        check("to_main_wait", {30'd0, mem_req, bus_err}, 32'd2);
      end else begin
        check("to_wait_err", 32'(bus_err_b), 32'd0);
        check("to_wait_req", 32'(mem_req_b), 32'd1);
      end
      @(posedge clk);
      #1;
    end
    check("to_retired_b", 32'(retired_b), 32'd0);

    // Counter wrap on the 4-bit instance after 16 retirements
    do_reset();
    op = 7'b0110011; funct3 = 3'b000;
    for (int n = 0; n < 16; n++) run_instr("wrap", K_R, 0, 0);
    check("wrap_zero", 32'(retired_b), 32'd0);
    check("wrap_main16", retired, 32'd16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle FSM control unit for the RV32I datapath, replacing the single-cycle main decoder plus ALU-op glue. It sequences each instruction through fetch, decode, execute, memory and writeback, and drives all datapath enables and muxes. It also resolves branches from comparator flags, waits on a ready/valid-style memory handshake, traps illegal opcodes and counts retired instructions.

## Interface
- CNT_W, 32, width of retired-instruction counter
- MEM_TIMEOUT, 0, max cycles waiting for mem_ready before bus error; 0 = wait forever
- TRAP_HALT, 1, 1 = park in TRAP on illegal/bus error; 0 = flag for one cycle then resume FETCH
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous active-low reset
- op  in  7  instr[6:0] from instruction register
- funct3  in  3  instr[14:12]
- zero, lt, ltu  in  1 each  comparator flags of rs1-rs2 (eq, signed lt, unsigned lt)
- mem_ready  in  1  memory completes current access this cycle
- mem_req  out  1  memory access active
- IRWrite, PCWrite, RegWrite, MemWrite  out  1 each  register/memory enables
- AdrSrc  out  1  0 = PC, 1 = ALUOut
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1, 11 zero
- ALUSrcB  out  2  00 rs2, 01 imm, 10 const 4
- ALUOp  out  2  00 add, 01 sub/compare, 10 funct-decoded
- ResultSrc  out  2  00 ALUOut, 01 ReadData, 10 ALUResult
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- Load  out  3  lb 000, lh 001, lw 010, lbu 011, lhu 100
- Store  out  2  sb 00, sh 01, sw 10
- illegal, bus_err  out  1 each  trap cause flags
- retired  out  CNT_W  retired-instruction count

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I, ALUWB, BRANCH, JAL, JALR, JALR_LINK, UPPER, TRAP.
- Signals not listed for a state are 0. ImmSrc, Load and Store are combinational from op/funct3 in every state.
- FETCH:
  - Outputs: mem_req, AdrSrc=0, A=00, B=10, ALUOp=00, ResultSrc=10.
  - On mem_ready: IRWrite=1, PCWrite=1, go to DECODE. Otherwise hold.
- DECODE:
  - Outputs: A=01, B=01, ALUOp=00 (branch/jal target to ALUOut).
  - Next state by op: 0000011/0100011 → MEMADR; 0110011 → EXEC_R; 0010011 → EXEC_I; 1100011 → BRANCH; 1101111 → JAL; 1100111 → JALR; 0110111/0010111 → UPPER; else → TRAP with illegal.
  - Illegal funct3 also goes to TRAP: load 011/110/111, store ≥011, branch 010/011.
- MEMADR: A=10, B=01, ALUOp=00. Load → MEMREAD; store → MEMWRITE.
- MEMREAD: mem_req, AdrSrc=1. On mem_ready → MEMWB.
- MEMWB: ResultSrc=01, RegWrite → FETCH.
- MEMWRITE: mem_req, AdrSrc=1, MemWrite. On mem_ready → FETCH.
- EXEC_R: A=10, B=00, ALUOp=10 → ALUWB.
- EXEC_I: A=10, B=01, ALUOp=10 → ALUWB.
- ALUWB: ResultSrc=00, RegWrite → FETCH.
- BRANCH: A=10, B=00, ALUOp=01, ResultSrc=00.
  - PCWrite = taken: beq zero, bne !zero, blt lt, bge !lt, bltu ltu, bgeu !ltu.
  - Next → FETCH.
- JAL: ResultSrc=00, PCWrite; A=01, B=10 (link into ALUOut) → ALUWB.
- JALR: A=10, B=01, ALUOp=00, ResultSrc=10, PCWrite → JALR_LINK.
- JALR_LINK: A=01, B=10 → ALUWB.
- UPPER: A=11 (lui) or 01 (auipc), B=01, ALUOp=00 → ALUWB.
- TRAP:
  - illegal or bus_err held while in TRAP.
  - TRAP_HALT=1: stay until reset.
  - TRAP_HALT=0: one cycle, then FETCH; the trapping instruction is not retired.
- Timeout:
  - Wait counter clears on entry to any mem_req state.
  - If MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT without mem_ready: go to TRAP with bus_err; no enable fires that cycle.
- retired increments by 1 on every transition into FETCH from a non-TRAP state. It wraps modulo 2^CNT_W.

## Timing
- Reset (asynchronous, low): state=FETCH, retired=0, wait counter=0, illegal=bus_err=0. Enables are low while reset is asserted.
- Release: first fetch request in the first cycle after reset goes high.
- Cycle counts with zero-wait memory: R/I/upper 4, load 5, store 4, branch 3, jal 4, jalr 5.
- Each memory wait cycle adds 1; enables for that access fire only in the mem_ready cycle.
- mem_ready outside mem_req states is ignored.
- Reset mid-instruction aborts immediately; no partial writes after reset falls.
- All outputs other than state/counters are combinational from state and inputs.

## Test plan
- add x3,x1,x2 (0x002081B3), mem_ready=1 → FETCH, DECODE, EXEC_R, ALUWB; RegWrite in cycle 4; retired 0→1.
- lw with mem_ready low 3 cycles in MEMREAD → MEMREAD held 4 cycles, RegWrite only in MEMWB; total 8 cycles.
- bne with zero=0, then zero=1 → PCWrite=1 in BRANCH for the first, 0 for the second; both retire.
- op=0000000, TRAP_HALT=1 → TRAP with illegal=1, held 20 cycles; retired unchanged; reset low returns to FETCH with all outputs cleared.
- MEM_TIMEOUT=4, mem_ready never asserted in FETCH → bus_err after 4 cycles. With TRAP_HALT=0, re-enters FETCH one cycle later.
- retired preset to all-ones (CNT_W=4, 15 instructions) → the next retirement wraps to 0.
